// File: rtl/hazard_bypass_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_bypass_unit_if
//   Bundles every pipeline-facing signal of the hazard/bypass unit.
//   master : pipeline side (drives register addresses, enables, values and
//            long-op events; receives bypass values, stall and scoreboard)
//   slave  : hazard_bypass_unit side
//   Ports (master view, out = driven by the pipeline):
//     id_*      out  ID-stage sources, destination, branch/long flags
//     ex_*      out  ID_EXE sources, destination, load flag, long-op issue
//     exe_mem_* out  EXE_MEM producer (addr/value/we/load)
//     mem_wb_*  out  MEM_WB producer (addr/value/we)
//     long_wb_* out  long-op result entering MEM_WB
//     ex_fwd_*  in   EXE bypass hit/value per source port
//     id_fwd_*  in   ID bypass hit/value per source port
//     stall_id  in   hold PC/IF_ID, bubble ID_EXE
//     sb_busy   in   scoreboard busy bits, one per GPR
//     sb_count  in   outstanding long ops
//     stall_cnt in   stall-cycle counter
// ---------------------------------------------------------------------------
interface hazard_bypass_unit_if #(
  parameter int XLEN   = 32,
  parameter int RADDR  = 5,
  parameter int NUM_RP = 2,
  parameter int SB_MAX = 4
);
  localparam int NREG = 1 << RADDR;
  localparam int CW   = $clog2(SB_MAX + 1);

  logic [NUM_RP*RADDR-1:0] id_rs_addr;
  logic [NUM_RP-1:0]       id_rs_re;
  logic [RADDR-1:0]        id_rd_addr;
  logic                    id_rd_we;
  logic                    id_is_branch;
  logic                    id_is_long;

  logic [NUM_RP*RADDR-1:0] ex_rs_addr;
  logic [NUM_RP-1:0]       ex_rs_re;
  logic [RADDR-1:0]        ex_rd_addr;
  logic                    ex_rd_we;
  logic                    ex_mem_re;
  logic                    ex_long_issue;

  logic [RADDR-1:0]        exe_mem_rd_addr;
  logic [XLEN-1:0]         exe_mem_rd_val;
  logic                    exe_mem_rd_we;
  logic                    exe_mem_mem_re;

  logic [RADDR-1:0]        mem_wb_rd_addr;
  logic [XLEN-1:0]         mem_wb_rd_val;
  logic                    mem_wb_rd_we;

  logic                    long_wb_valid;
  logic [RADDR-1:0]        long_wb_addr;

  logic [NUM_RP-1:0]       ex_fwd_hit;
  logic [NUM_RP*XLEN-1:0]  ex_fwd_val;
  logic [NUM_RP-1:0]       id_fwd_hit;
  logic [NUM_RP*XLEN-1:0]  id_fwd_val;
  logic                    stall_id;
  logic [NREG-1:0]         sb_busy;
  logic [CW-1:0]           sb_count;
  logic [31:0]             stall_cnt;

  modport master (
    output id_rs_addr, id_rs_re, id_rd_addr, id_rd_we, id_is_branch, id_is_long,
    output ex_rs_addr, ex_rs_re, ex_rd_addr, ex_rd_we, ex_mem_re, ex_long_issue,
    output exe_mem_rd_addr, exe_mem_rd_val, exe_mem_rd_we, exe_mem_mem_re,
    output mem_wb_rd_addr, mem_wb_rd_val, mem_wb_rd_we,
    output long_wb_valid, long_wb_addr,
    input  ex_fwd_hit, ex_fwd_val, id_fwd_hit, id_fwd_val,
    input  stall_id, sb_busy, sb_count, stall_cnt
  );

  modport slave (
    input  id_rs_addr, id_rs_re, id_rd_addr, id_rd_we, id_is_branch, id_is_long,
    input  ex_rs_addr, ex_rs_re, ex_rd_addr, ex_rd_we, ex_mem_re, ex_long_issue,
    input  exe_mem_rd_addr, exe_mem_rd_val, exe_mem_rd_we, exe_mem_mem_re,
    input  mem_wb_rd_addr, mem_wb_rd_val, mem_wb_rd_we,
    input  long_wb_valid, long_wb_addr,
    output ex_fwd_hit, ex_fwd_val, id_fwd_hit, id_fwd_val,
    output stall_id, sb_busy, sb_count, stall_cnt
  );
endinterface

// File: rtl/hazard_bypass_unit.sv
// ---------------------------------------------------------------------------
// hazard_bypass_unit
//   Operand-hazard controller for the 5-stage core. Bypasses EXE_MEM and
//   MEM_WB results to NUM_RP source ports in both ID and EXE, and raises a
//   single ID stall for load-use, branch-on-fresh-result and (optionally)
//   multi-cycle scoreboard hazards. Counts stalled cycles.
//   Ports:
//     clk  in  core clock
//     rst  in  synchronous active-high reset
//     bus  hazard_bypass_unit_if.slave, all pipeline signals
//   Configuration:
//     HAZ_LONG_SB_EN  when defined, the long-op scoreboard, sb_count and the
//                     long-op stall terms exist; otherwise long-op inputs are
//                     ignored and sb_busy/sb_count read as zero.
// ---------------------------------------------------------------------------
module hazard_bypass_unit #(
  parameter int XLEN   = 32,
  parameter int RADDR  = 5,
  parameter int NUM_RP = 2,
  parameter int SB_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_bypass_unit_if.slave  bus
);
  localparam int NREG = 1 << RADDR;
  localparam int CW   = $clog2(SB_MAX + 1);

  // A source depends on a producer when it reads a real register (not x0)
  // that the producer is actually writing.
  function automatic logic src_match(input logic [RADDR-1:0] a,
                                     input logic             re,
                                     input logic [RADDR-1:0] rd,
                                     input logic             we);
    return re && (a != '0) && (a == rd) && we;
  endfunction

  // -------------------------------------------------------------------------
  // Bypass network: EXE_MEM first (unless it is a load, whose data is not yet
  // available), then MEM_WB.
  // -------------------------------------------------------------------------
  logic [NUM_RP-1:0]      ex_hit, id_hit;
  logic [NUM_RP*XLEN-1:0] ex_val, id_val;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    ex_hit = '0;
    ex_val = '0;
    id_hit = '0;
    id_val = '0;
    for (int p = 0; p < NUM_RP; p++) begin
      if (src_match(bus.ex_rs_addr[p*RADDR +: RADDR], bus.ex_rs_re[p],
                    bus.exe_mem_rd_addr, bus.exe_mem_rd_we) && !bus.exe_mem_mem_re) begin
        ex_hit[p]                = 1'b1;
        ex_val[p*XLEN +: XLEN]   = bus.exe_mem_rd_val;
      end else if (src_match(bus.ex_rs_addr[p*RADDR +: RADDR], bus.ex_rs_re[p],
                             bus.mem_wb_rd_addr, bus.mem_wb_rd_we)) begin
        ex_hit[p]                = 1'b1;
        ex_val[p*XLEN +: XLEN]   = bus.mem_wb_rd_val;
      end

      if (src_match(bus.id_rs_addr[p*RADDR +: RADDR], bus.id_rs_re[p],
                    bus.exe_mem_rd_addr, bus.exe_mem_rd_we) && !bus.exe_mem_mem_re) begin
        id_hit[p]                = 1'b1;
        id_val[p*XLEN +: XLEN]   = bus.exe_mem_rd_val;
      end else if (src_match(bus.id_rs_addr[p*RADDR +: RADDR], bus.id_rs_re[p],
                             bus.mem_wb_rd_addr, bus.mem_wb_rd_we)) begin
        id_hit[p]                = 1'b1;
        id_val[p*XLEN +: XLEN]   = bus.mem_wb_rd_val;
      end
    end
  end

  assign bus.ex_fwd_hit = ex_hit;
  assign bus.ex_fwd_val = ex_val;
  assign bus.id_fwd_hit = id_hit;
  assign bus.id_fwd_val = id_val;

  // -------------------------------------------------------------------------
  // Long-op scoreboard
  // -------------------------------------------------------------------------
`ifdef HAZ_LONG_SB_EN
  logic [NREG-1:0] sb_busy_q, sb_busy_d;
  logic [CW-1:0]   sb_count_q, sb_count_d;
  logic            sb_set, sb_clr;

  always_comb begin
    sb_set = bus.ex_long_issue && (bus.ex_rd_addr != '0);
    // A clear only counts when it retires something really outstanding, so a
    // stray writeback can never underflow the counter.
    sb_clr = bus.long_wb_valid && sb_busy_q[bus.long_wb_addr] && (sb_count_q != '0);

    sb_busy_d = sb_busy_q;
    if (sb_clr) sb_busy_d[bus.long_wb_addr] = 1'b0;
    // Applied after the clear so a same-register issue/writeback stays busy.
    if (sb_set) sb_busy_d[bus.ex_rd_addr] = 1'b1;

    sb_count_d = sb_count_q;
    case ({sb_set, sb_clr})
      2'b10:   sb_count_d = sb_count_q + CW'(1);
      2'b01:   sb_count_d = sb_count_q - CW'(1);
      default: sb_count_d = sb_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the busy vector is reset like any control register; a stale bit
    // after reset would stall its register forever.
    if (rst) begin
      sb_busy_q  <= '0;
      sb_count_q <= '0;
    end else begin
      sb_busy_q  <= sb_busy_d;
      sb_count_q <= sb_count_d;
    end
  end

  assign bus.sb_busy  = sb_busy_q;
  assign bus.sb_count = sb_count_q;
`else
  assign bus.sb_busy  = '0;
  assign bus.sb_count = '0;
`endif

  // -------------------------------------------------------------------------
  // ID stall
  // -------------------------------------------------------------------------
  logic stall;

  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NUM_RP; p++) begin
      // Load-use: the loaded value appears only after MEM.
      stall |= src_match(bus.id_rs_addr[p*RADDR +: RADDR], bus.id_rs_re[p],
                         bus.ex_rd_addr, bus.ex_rd_we) && bus.ex_mem_re;
      // Branches resolve in ID, so an ALU result still in EXE is too late.
      stall |= bus.id_is_branch &&
               src_match(bus.id_rs_addr[p*RADDR +: RADDR], bus.id_rs_re[p],
                         bus.ex_rd_addr, bus.ex_rd_we);
      // A branch cannot take load data straight out of EXE_MEM either.
      stall |= bus.id_is_branch && bus.exe_mem_mem_re &&
               src_match(bus.id_rs_addr[p*RADDR +: RADDR], bus.id_rs_re[p],
                         bus.exe_mem_rd_addr, bus.exe_mem_rd_we);
`ifdef HAZ_LONG_SB_EN
      // The long op being dispatched is not yet on the scoreboard.
      stall |= bus.ex_long_issue &&
               src_match(bus.id_rs_addr[p*RADDR +: RADDR], bus.id_rs_re[p],
                         bus.ex_rd_addr, bus.ex_rd_we);
      stall |= bus.id_rs_re[p] && (bus.id_rs_addr[p*RADDR +: RADDR] != '0) &&
               sb_busy_q[bus.id_rs_addr[p*RADDR +: RADDR]];
`endif
    end
`ifdef HAZ_LONG_SB_EN
    stall |= bus.id_rd_we && (bus.id_rd_addr != '0) && sb_busy_q[bus.id_rd_addr];
    stall |= bus.id_is_long && (sb_count_q == CW'(SB_MAX));
`endif
  end

  assign bus.stall_id = stall;

  // -------------------------------------------------------------------------
  // Stall-cycle counter (wraps naturally)
  // -------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_bypass_unit
//   Directed scenarios plus randomized traffic against a behavioural model
//   (per-register busy array, outstanding count, stall tally). Works with and
//   without HAZ_LONG_SB_EN.
// ---------------------------------------------------------------------------
module tb_hazard_bypass_unit;
  localparam int XLEN   = 32;
  localparam int RADDR  = 5;
  localparam int NUM_RP = 2;
  localparam int SB_MAX = 4;
  localparam int NREG   = 1 << RADDR;
  localparam int CW     = $clog2(SB_MAX + 1);
`ifdef HAZ_LONG_SB_EN
  localparam bit LONG = 1'b1;
`else
  localparam bit LONG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_bypass_unit_if #(.XLEN(XLEN), .RADDR(RADDR), .NUM_RP(NUM_RP), .SB_MAX(SB_MAX)) bus ();

  hazard_bypass_unit #(.XLEN(XLEN), .RADDR(RADDR), .NUM_RP(NUM_RP), .SB_MAX(SB_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_busy [NREG];
  int          m_count;
  bit [31:0]   m_cnt;

  // Model expectations for the current inputs
  logic [NUM_RP-1:0]      e_ex_hit, e_id_hit;
  logic [NUM_RP*XLEN-1:0] e_ex_val, e_id_val;
  logic                   e_stall;
  logic [NREG-1:0]        e_busy;

  function automatic bit dep(input int a, input bit re, input int rd, input bit we);
    return re && a != 0 && a == rd && we;
  endfunction

  task automatic model_eval();
    int a, ex_rd, em_rd, wb_rd;
    bit re;
    e_ex_hit = '0; e_ex_val = '0; e_id_hit = '0; e_id_val = '0; e_stall = 1'b0;
    ex_rd = int'(bus.ex_rd_addr);
    em_rd = int'(bus.exe_mem_rd_addr);
    wb_rd = int'(bus.mem_wb_rd_addr);
    for (int p = 0; p < NUM_RP; p++) begin
      a  = int'(bus.ex_rs_addr[p*RADDR +: RADDR]);
      re = bus.ex_rs_re[p];
      if (dep(a, re, em_rd, bus.exe_mem_rd_we) && !bus.exe_mem_mem_re) begin
        e_ex_hit[p] = 1'b1; e_ex_val[p*XLEN +: XLEN] = bus.exe_mem_rd_val;
      end else if (dep(a, re, wb_rd, bus.mem_wb_rd_we)) begin
        e_ex_hit[p] = 1'b1; e_ex_val[p*XLEN +: XLEN] = bus.mem_wb_rd_val;
      end
      a  = int'(bus.id_rs_addr[p*RADDR +: RADDR]);
      re = bus.id_rs_re[p];
      if (dep(a, re, em_rd, bus.exe_mem_rd_we) && !bus.exe_mem_mem_re) begin
        e_id_hit[p] = 1'b1; e_id_val[p*XLEN +: XLEN] = bus.exe_mem_rd_val;
      end else if (dep(a, re, wb_rd, bus.mem_wb_rd_we)) begin
        e_id_hit[p] = 1'b1; e_id_val[p*XLEN +: XLEN] = bus.mem_wb_rd_val;
      end
      if (dep(a, re, ex_rd, bus.ex_rd_we) && bus.ex_mem_re) e_stall = 1'b1;
      if (bus.id_is_branch && dep(a, re, ex_rd, bus.ex_rd_we)) e_stall = 1'b1;
      if (bus.id_is_branch && bus.exe_mem_mem_re && dep(a, re, em_rd, bus.exe_mem_rd_we)) e_stall = 1'b1;
      if (LONG && bus.ex_long_issue && dep(a, re, ex_rd, bus.ex_rd_we)) e_stall = 1'b1;
      if (LONG && re && a != 0 && m_busy[a]) e_stall = 1'b1;
    end
    if (LONG && bus.id_rd_we && bus.id_rd_addr != 0 && m_busy[int'(bus.id_rd_addr)]) e_stall = 1'b1;
    if (LONG && bus.id_is_long && m_count == SB_MAX) e_stall = 1'b1;
    for (int i = 0; i < NREG; i++) e_busy[i] = m_busy[i];
  endtask

  task automatic model_commit();
    bit do_set, do_clr;
    model_eval();
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_count = 0;
      m_cnt   = 0;
    end else begin
      if (e_stall) m_cnt = m_cnt + 1;
      if (LONG) begin
        do_set = bus.ex_long_issue && bus.ex_rd_addr != 0;
        do_clr = bus.long_wb_valid && m_busy[int'(bus.long_wb_addr)] && m_count > 0;
        if (do_clr) m_busy[int'(bus.long_wb_addr)] = 1'b0;
        if (do_set) m_busy[int'(bus.ex_rd_addr)] = 1'b1;
        m_count = m_count + int'(do_set) - int'(do_clr);
      end
    end
  endtask

  // Advance one clock; inputs stay put across the edge, model follows the DUT.
  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_rs_addr = '0; bus.id_rs_re = '0; bus.id_rd_addr = '0; bus.id_rd_we = 1'b0;
    bus.id_is_branch = 1'b0; bus.id_is_long = 1'b0;
    bus.ex_rs_addr = '0; bus.ex_rs_re = '0; bus.ex_rd_addr = '0; bus.ex_rd_we = 1'b0;
    bus.ex_mem_re = 1'b0; bus.ex_long_issue = 1'b0;
    bus.exe_mem_rd_addr = '0; bus.exe_mem_rd_val = '0; bus.exe_mem_rd_we = 1'b0; bus.exe_mem_mem_re = 1'b0;
    bus.mem_wb_rd_addr = '0; bus.mem_wb_rd_val = '0; bus.mem_wb_rd_we = 1'b0;
    bus.long_wb_valid = 1'b0; bus.long_wb_addr = '0;
  endtask

  task automatic issue_long(input int rd);
    idle();
    bus.ex_long_issue = 1'b1; bus.ex_rd_addr = RADDR'(rd); bus.ex_rd_we = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0; #1;
    checks++; if (bus.sb_busy !== '0) begin failures++; $display("FAIL reset_sb_busy got=%h exp=0", bus.sb_busy); end
    checks++; if (bus.sb_count !== '0) begin failures++; $display("FAIL reset_sb_count got=%0d exp=0", bus.sb_count); end
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall_id got=%b exp=0", bus.stall_id); end
  endtask

  task automatic test_ex_bypass();
    idle();
    bus.exe_mem_rd_addr = 5; bus.exe_mem_rd_val = 32'h11; bus.exe_mem_rd_we = 1'b1;
    bus.mem_wb_rd_addr  = 5; bus.mem_wb_rd_val  = 32'h22; bus.mem_wb_rd_we  = 1'b1;
    bus.ex_rs_addr[0 +: RADDR] = 5; bus.ex_rs_re[0] = 1'b1;
    bus.id_rs_addr[RADDR +: RADDR] = 5; bus.id_rs_re[1] = 1'b1;
    #1;
    checks++; if (bus.ex_fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL exbyp_hit got=%b exp=1", bus.ex_fwd_hit[0]); end
    checks++; if (bus.ex_fwd_val[0 +: XLEN] !== 32'h11) begin failures++; $display("FAIL exbyp_val_exemem got=%h exp=11", bus.ex_fwd_val[0 +: XLEN]); end
    checks++; if (bus.id_fwd_val[XLEN +: XLEN] !== 32'h11) begin failures++; $display("FAIL idbyp_val_exemem got=%h exp=11", bus.id_fwd_val[XLEN +: XLEN]); end
    checks++; if (bus.ex_fwd_hit[1] !== 1'b0) begin failures++; $display("FAIL exbyp_port1_idle got=%b exp=0", bus.ex_fwd_hit[1]); end
    bus.exe_mem_mem_re = 1'b1; #1;
    checks++; if (bus.ex_fwd_val[0 +: XLEN] !== 32'h22) begin failures++; $display("FAIL exbyp_val_memwb got=%h exp=22", bus.ex_fwd_val[0 +: XLEN]); end
    checks++; if (bus.id_fwd_hit[1] !== 1'b1 || bus.id_fwd_val[XLEN +: XLEN] !== 32'h22) begin
      failures++; $display("FAIL idbyp_memwb got=%b/%h exp=1/22", bus.id_fwd_hit[1], bus.id_fwd_val[XLEN +: XLEN]); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL exbyp_nostall got=%b exp=0", bus.stall_id); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    bus.ex_rd_addr = 7; bus.ex_rd_we = 1'b1; bus.ex_mem_re = 1'b1;
    bus.id_rs_addr[RADDR +: RADDR] = 7; bus.id_rs_re[1] = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL loaduse_stall got=%b exp=1", bus.stall_id); end
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL loaduse_cnt_before got=%0d exp=0", bus.stall_cnt); end
    tick();
    // bubble in ID_EXE, load now in EXE_MEM
    bus.ex_rd_we = 1'b0; bus.ex_mem_re = 1'b0;
    bus.exe_mem_rd_addr = 7; bus.exe_mem_rd_we = 1'b1; bus.exe_mem_mem_re = 1'b1; bus.exe_mem_rd_val = 32'hDEAD;
    #1;
    checks++; if (bus.stall_cnt !== 32'd1) begin failures++; $display("FAIL loaduse_cnt_after got=%0d exp=1", bus.stall_cnt); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL loaduse_bubble got=%b exp=0", bus.stall_id); end
    tick();
    idle();
    bus.mem_wb_rd_addr = 7; bus.mem_wb_rd_val = 32'hABCD; bus.mem_wb_rd_we = 1'b1;
    bus.ex_rs_addr[RADDR +: RADDR] = 7; bus.ex_rs_re[1] = 1'b1;
    #1;
    checks++; if (bus.ex_fwd_hit[1] !== 1'b1 || bus.ex_fwd_val[XLEN +: XLEN] !== 32'hABCD) begin
      failures++; $display("FAIL loaduse_memwb got=%b/%h exp=1/abcd", bus.ex_fwd_hit[1], bus.ex_fwd_val[XLEN +: XLEN]); end
    tick();
  endtask

  task automatic test_branch();
    idle();
    bus.id_is_branch = 1'b1; bus.id_rs_addr[0 +: RADDR] = 3; bus.id_rs_re[0] = 1'b1;
    bus.ex_rd_addr = 3; bus.ex_rd_we = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL branch_alu_stall got=%b exp=1", bus.stall_id); end
    tick();
    bus.ex_rd_we = 1'b0;
    bus.exe_mem_rd_addr = 3; bus.exe_mem_rd_val = 32'h33; bus.exe_mem_rd_we = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL branch_release got=%b exp=0", bus.stall_id); end
    checks++; if (bus.id_fwd_hit[0] !== 1'b1 || bus.id_fwd_val[0 +: XLEN] !== 32'h33) begin
      failures++; $display("FAIL branch_idbyp got=%b/%h exp=1/33", bus.id_fwd_hit[0], bus.id_fwd_val[0 +: XLEN]); end
    bus.exe_mem_mem_re = 1'b1; #1;
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL branch_load_exemem got=%b exp=1", bus.stall_id); end
    tick();
  endtask

  task automatic test_scoreboard();
    issue_long(9);
    idle(); #1;
    checks++; if (bus.sb_busy[9] !== LONG) begin failures++; $display("FAIL sb_set_busy got=%b exp=%b", bus.sb_busy[9], LONG); end
    checks++; if (bus.sb_count !== CW'(LONG)) begin failures++; $display("FAIL sb_set_count got=%0d exp=%0d", bus.sb_count, LONG); end
    bus.id_rs_addr[0 +: RADDR] = 9; bus.id_rs_re[0] = 1'b1;
    #1;
    checks++; if (bus.stall_id !== LONG) begin failures++; $display("FAIL sb_raw_stall got=%b exp=%b", bus.stall_id, LONG); end
    tick(); tick();
    bus.long_wb_valid = 1'b1; bus.long_wb_addr = 9; #1;
    checks++; if (bus.stall_id !== LONG) begin failures++; $display("FAIL sb_wb_cycle_stall got=%b exp=%b", bus.stall_id, LONG); end
    tick();
    bus.long_wb_valid = 1'b0;
    bus.mem_wb_rd_addr = 9; bus.mem_wb_rd_val = 32'h99; bus.mem_wb_rd_we = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL sb_after_wb got=%b exp=0", bus.stall_id); end
    checks++; if (bus.id_fwd_val[0 +: XLEN] !== 32'h99) begin failures++; $display("FAIL sb_after_wb_byp got=%h exp=99", bus.id_fwd_val[0 +: XLEN]); end
    checks++; if (bus.sb_count !== '0) begin failures++; $display("FAIL sb_after_wb_count got=%0d exp=0", bus.sb_count); end
    // issue and writeback to the same register in one cycle
    issue_long(9);
    bus.ex_long_issue = 1'b1; bus.ex_rd_addr = 9; bus.ex_rd_we = 1'b1;
    bus.long_wb_valid = 1'b1; bus.long_wb_addr = 9;
    tick();
    idle(); #1;
    checks++; if (bus.sb_busy[9] !== LONG || bus.sb_count !== CW'(LONG)) begin
      failures++; $display("FAIL sb_same_setclr got=%b/%0d exp=%b/%0d", bus.sb_busy[9], bus.sb_count, LONG, LONG); end
    bus.long_wb_valid = 1'b1; bus.long_wb_addr = 9; tick();
    bus.long_wb_addr = 12; tick();   // stray clear with nothing outstanding
    idle(); #1;
    checks++; if (bus.sb_count !== '0 || bus.sb_busy !== '0) begin
      failures++; $display("FAIL sb_no_underflow got=%0d/%h exp=0/0", bus.sb_count, bus.sb_busy); end
    // WAW against a pending long op, and RAW against the one being issued
    issue_long(4);
    idle(); bus.id_rd_we = 1'b1; bus.id_rd_addr = 4; #1;
    checks++; if (bus.stall_id !== LONG) begin failures++; $display("FAIL sb_waw got=%b exp=%b", bus.stall_id, LONG); end
    idle();
    bus.ex_long_issue = 1'b1; bus.ex_rd_addr = 6; bus.ex_rd_we = 1'b1;
    bus.id_rs_addr[RADDR +: RADDR] = 6; bus.id_rs_re[1] = 1'b1; #1;
    checks++; if (bus.stall_id !== LONG) begin failures++; $display("FAIL sb_issue_raw got=%b exp=%b", bus.stall_id, LONG); end
    idle(); bus.long_wb_valid = 1'b1; bus.long_wb_addr = 4; tick();
    idle(); tick();
  endtask

  task automatic test_sb_capacity();
    for (int r = 1; r <= SB_MAX; r++) issue_long(r);
    idle(); bus.id_is_long = 1'b1; #1;
    checks++; if (bus.sb_count !== CW'(LONG ? SB_MAX : 0)) begin failures++; $display("FAIL cap_count got=%0d", bus.sb_count); end
    checks++; if (bus.stall_id !== LONG) begin failures++; $display("FAIL cap_stall got=%b exp=%b", bus.stall_id, LONG); end
    bus.long_wb_valid = 1'b1; bus.long_wb_addr = 1; #1;
    checks++; if (bus.stall_id !== LONG) begin failures++; $display("FAIL cap_stall_wbcycle got=%b exp=%b", bus.stall_id, LONG); end
    tick();
    bus.long_wb_valid = 1'b0; #1;
    checks++; if (bus.sb_count !== CW'(LONG ? SB_MAX - 1 : 0)) begin failures++; $display("FAIL cap_count_after got=%0d", bus.sb_count); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL cap_release got=%b exp=0", bus.stall_id); end
    idle(); bus.long_wb_valid = 1'b1; bus.long_wb_addr = 2; tick();
    idle();
  endtask

  task automatic test_mid_reset();
    #1;
    checks++; if (bus.sb_count !== CW'(LONG ? 2 : 0)) begin failures++; $display("FAIL midrst_pre_count got=%0d", bus.sb_count); end
    rst = 1'b1;
    bus.ex_long_issue = 1'b1; bus.ex_rd_addr = 5; bus.ex_rd_we = 1'b1;
    tick();
    rst = 1'b0; idle(); #1;
    checks++; if (bus.sb_busy !== '0 || bus.sb_count !== '0 || bus.stall_cnt !== 32'd0) begin
      failures++; $display("FAIL midrst_state got=%h/%0d/%0d exp=0/0/0", bus.sb_busy, bus.sb_count, bus.stall_cnt); end
    // x0 never hits nor stalls
    bus.id_rs_re = '1; bus.ex_rs_re = '1; bus.id_is_branch = 1'b1;
    bus.ex_rd_we = 1'b1; bus.ex_mem_re = 1'b1; bus.ex_long_issue = 1'b1;
    bus.exe_mem_rd_we = 1'b1; bus.exe_mem_mem_re = 1'b1; bus.exe_mem_rd_val = 32'h5;
    bus.mem_wb_rd_we = 1'b1; bus.mem_wb_rd_val = 32'h6; bus.id_rd_we = 1'b1;
    bus.long_wb_valid = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", bus.stall_id); end
    checks++; if (bus.id_fwd_hit !== '0 || bus.ex_fwd_hit !== '0 || bus.ex_fwd_val !== '0) begin
      failures++; $display("FAIL x0_hit got=%b/%b/%h exp=0", bus.id_fwd_hit, bus.ex_fwd_hit, bus.ex_fwd_val); end
    tick(); idle(); #1;
    checks++; if (bus.sb_count !== '0) begin failures++; $display("FAIL x0_no_sb got=%0d exp=0", bus.sb_count); end
  endtask

  task automatic test_random();
    logic [NUM_RP*RADDR-1:0] a_id, a_ex;
    int rd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NUM_RP; p++) begin
        a_id[p*RADDR +: RADDR] = RADDR'($urandom_range(0, 7));
        a_ex[p*RADDR +: RADDR] = RADDR'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 63) == 0);
      bus.id_rs_addr = a_id; bus.id_rs_re = NUM_RP'($urandom);
      bus.ex_rs_addr = a_ex; bus.ex_rs_re = NUM_RP'($urandom);
      bus.id_rd_addr = RADDR'($urandom_range(0, 7)); bus.id_rd_we = 1'($urandom);
      bus.id_is_branch = ($urandom_range(0, 3) == 0); bus.id_is_long = 1'($urandom);
      rd = $urandom_range(0, 7);
      bus.ex_rd_addr = RADDR'(rd); bus.ex_rd_we = 1'($urandom);
      bus.ex_mem_re = ($urandom_range(0, 3) == 0);
      bus.ex_long_issue = ($urandom_range(0, 3) == 0) && m_count < SB_MAX && !m_busy[rd];
      bus.exe_mem_rd_addr = RADDR'($urandom_range(0, 7)); bus.exe_mem_rd_val = $urandom;
      bus.exe_mem_rd_we = 1'($urandom); bus.exe_mem_mem_re = ($urandom_range(0, 3) == 0);
      bus.mem_wb_rd_addr = RADDR'($urandom_range(0, 7)); bus.mem_wb_rd_val = $urandom;
      bus.mem_wb_rd_we = 1'($urandom);
      bus.long_wb_valid = ($urandom_range(0, 2) == 0); bus.long_wb_addr = RADDR'($urandom_range(0, 7));
      #1;
      model_eval();
      checks++; if (bus.ex_fwd_hit !== e_ex_hit) begin failures++; $display("FAIL rnd_ex_hit cyc=%0d got=%b exp=%b", cyc, bus.ex_fwd_hit, e_ex_hit); end
      checks++; if (bus.ex_fwd_val !== e_ex_val) begin failures++; $display("FAIL rnd_ex_val cyc=%0d got=%h exp=%h", cyc, bus.ex_fwd_val, e_ex_val); end
      checks++; if (bus.id_fwd_hit !== e_id_hit) begin failures++; $display("FAIL rnd_id_hit cyc=%0d got=%b exp=%b", cyc, bus.id_fwd_hit, e_id_hit); end
      checks++; if (bus.id_fwd_val !== e_id_val) begin failures++; $display("FAIL rnd_id_val cyc=%0d got=%h exp=%h", cyc, bus.id_fwd_val, e_id_val); end
      checks++; if (bus.stall_id !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, bus.stall_id, e_stall); end
      checks++; if (bus.sb_busy !== e_busy) begin failures++; $display("FAIL rnd_sb_busy cyc=%0d got=%h exp=%h", cyc, bus.sb_busy, e_busy); end
      checks++; if (bus.sb_count !== CW'(m_count)) begin failures++; $display("FAIL rnd_sb_count cyc=%0d got=%0d exp=%0d", cyc, bus.sb_count, m_count); end
      checks++; if (bus.stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.stall_cnt, m_cnt); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_count = 0;
    m_cnt   = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_ex_bypass();
    test_load_use();
    test_branch();
    test_scoreboard();
    test_sb_capacity();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
